uart_mem_bridge: RTL and testbench
==================================

// Module: uart_mem_bridge
// PURPOSE
//  Parametrised UART<->memory loader/dumper. LOAD streams bytes from uart_rx
//  into a RAM, packing them little-endian into DATA_W-bit words. DUMP reads
//  words back and serialises them byte-by-byte to uart_tx. Adds a base address,
//  a run-time length, configurable RAM read latency and overrun detection.
//  Sits between the uart_rx/uart_tx pair and the data RAM port; the CPU/top
//  sequencer issues start pulses.
// PARAMETERS
//  ADDR_W  16  RAM address width (words)
//  DATA_W  8   RAM word width; multiple of 8; BPW = DATA_W/8 bytes per word
//  RD_LAT  2   cycles from mem_addr valid to mem_rdata valid (>=1)
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  reset       in   1       synchronous, active-high
//  load_start  in   1       pulse: begin LOAD (sampled in IDLE only)
//  dump_start  in   1       pulse: begin DUMP (sampled in IDLE only)
//  base_addr   in   ADDR_W  first word address, sampled with the start pulse
//  xfer_len    in   ADDR_W  word count, sampled with start; 0 means 2^ADDR_W
//  rx_done     in   1       one-cycle strobe: rx_byte valid
//  rx_byte     in   8       received byte
//  tx_ready    in   1       high while transmitter idle
//  tx_send     out  1       one-cycle request to send tx_byte
//  tx_byte     out  8       byte to transmit; stable from tx_send until tx_ready
//                           next rises
//  mem_we      out  1       one-cycle write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data
//  busy        out  1       high in any state other than IDLE
//  done        out  1       one-cycle pulse when a LOAD or DUMP completes
//  overrun     out  1       sticky: rx_done seen while not in RX_WAIT during a
//                           LOAD; cleared by the next accepted load_start
//  state_dbg   out  4       current state encoding, for LEDs
// BEHAVIOUR
//  - Reset: state=IDLE. Outputs tx_send, mem_we, busy, done, overrun = 0;
//    mem_addr, mem_wdata, tx_byte = 0. Reset mid-transfer aborts the transfer
//    at the same edge. No done pulse; no further writes or sends.
//  - Registers: word counter ADDR_W+1 bits, loaded with xfer_len (0 -> 2^ADDR_W);
//    byte index 0..BPW-1. mem_addr = base + i modulo 2^ADDR_W, so it wraps
//    past the top.
//  - IDLE: if load_start -> RX_WAIT; else if dump_start -> TX_RD. load_start
//    wins if both pulse together. Starts outside IDLE are ignored.
//  - RX_WAIT: on rx_done, place rx_byte in lane [8*k+7:8*k] (k = byte index).
//    If k < BPW-1: k++ and stay. Else -> RX_WR.
//  - RX_WR: mem_we=1 for exactly this cycle, with mem_wdata and mem_addr held.
//    Then -> RX_ADV.
//  - RX_ADV: counter--, addr++, k=0. Counter==0 -> DONE, else -> RX_WAIT.
//  - TX_RD: hold mem_addr for RD_LAT cycles, then latch mem_rdata into the
//    shift word. -> TX_REQ.
//  - TX_REQ: wait tx_ready=1. Then drive tx_send=1 for one cycle with
//    tx_byte = lane k. -> TX_ACK.
//  - TX_ACK: wait tx_ready=0, which acknowledges the request. -> TX_FIN.
//  - TX_FIN: wait tx_ready=1. If k < BPW-1: k++ -> TX_REQ. Else -> TX_ADV.
//  - TX_ADV: counter--, addr++, k=0. Counter==0 -> DONE, else -> TX_RD.
//  - DONE: done=1 for one cycle. -> IDLE.
//  - rx_done during DUMP is dropped and does not set overrun. mem_we is never
//    asserted during DUMP, and tx_send is never asserted during LOAD.
//  - LOAD latency: mem_we rises 1 cycle after the last rx_done of a word.
//    done follows 2 cycles after that last word's write.
// TESTING
//  1 DATA_W=8, base=0, len=4; rx 0x11,0x22,0x33,0x44 -> writes 0..3 in order,
//    one mem_we per byte, one done, overrun=0.
//  2 DATA_W=32, base=0x0010, len=2; rx 01..08 -> mem[0x10]=0x04030201 and
//    mem[0x11]=0x08070605; DUMP of the same range -> tx bytes 01..08 in order.
//  3 ADDR_W=4, base=0xE, len=4 -> writes to 0xE, 0xF, 0x0, 0x1. xfer_len=0 ->
//    16 words transferred.
//  4 load_start and dump_start pulsed together -> LOAD runs. A dump_start while
//    busy is ignored. rx_done injected during RX_WR -> overrun=1, byte dropped.
//  5 reset asserted mid-DUMP, after 2 bytes are sent -> next cycle busy=0,
//    tx_send=0, no done. A fresh DUMP then restarts at base_addr.
//  6 RD_LAT=3, with tx_ready held low for 50 cycles -> no tx_send until
//    tx_ready=1, and tx_byte equals mem_rdata of the addressed word.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// UART <-> RAM bridge: LOAD packs received bytes little-endian into DATA_W-bit
// words and writes them out; DUMP reads words back and sends them byte by byte.
module uart_mem_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] xfer_len,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [7:0]        tx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [3:0]        state_dbg
);

  localparam int BPW = DATA_W / 8;
  localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int LW  = $clog2(RD_LAT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(BPW - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RX_WAIT = 4'd1,
    S_RX_WR   = 4'd2,
    S_RX_ADV  = 4'd3,
    S_TX_RD   = 4'd4,
    S_TX_REQ  = 4'd5,
    S_TX_ACK  = 4'd6,
    S_TX_FIN  = 4'd7,
    S_TX_ADV  = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [KW-1:0]       k_q;
  logic [LW-1:0]       lat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   shift_q;
  logic [7:0]          tx_byte_q;
  logic                tx_send_q;
  logic                mem_we_q;
  logic                done_q;
  logic                overrun_q;
  logic [ADDR_W:0]     len_d;

  function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] w,
                                                  input logic [KW-1:0] k,
                                                  input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    for (int j = 0; j < BPW; j++)
      if (k == KW'(j)) r[8*j +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_lane(input logic [DATA_W-1:0] w,
                                          input logic [KW-1:0] k);
    logic [7:0] r;
    r = w[7:0];
    for (int j = 0; j < BPW; j++)
      if (k == KW'(j)) r = w[8*j +: 8];
    return r;
  endfunction

  // A zero length encodes the full 2^ADDR_W-word address space.
  always_comb begin
    len_d = {1'b0, xfer_len};
    if (xfer_len == '0) len_d = {1'b1, {ADDR_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_byte_q <= '0;
      tx_send_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      if (rx_done && (state_q == S_RX_WR || state_q == S_RX_ADV)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          k_q   <= '0;
          lat_q <= '0;
          if (load_start) begin
            state_q   <= S_RX_WAIT;
            addr_q    <= base_addr;
            cnt_q     <= len_d;
            overrun_q <= 1'b0;
          end else if (dump_start) begin
            state_q <= S_TX_RD;
            addr_q  <= base_addr;
            cnt_q   <= len_d;
          end
        end
        S_RX_WAIT: begin
          if (rx_done) begin
            wdata_q <= put_lane(wdata_q, k_q, rx_byte);
            if (k_q == K_LAST) begin
              state_q  <= S_RX_WR;
              mem_we_q <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        S_RX_WR: state_q <= S_RX_ADV;
        S_RX_ADV: begin
          cnt_q  <= cnt_q - (ADDR_W+1)'(1);
          addr_q <= addr_q + ADDR_W'(1);
          k_q    <= '0;
          if (cnt_q == (ADDR_W+1)'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RX_WAIT;
          end
        end
        // Address has been stable for RD_LAT cycles when lat_q reaches RD_LAT.
        S_TX_RD: begin
          if (lat_q == LW'(RD_LAT)) begin
            shift_q <= mem_rdata;
            lat_q   <= '0;
            state_q <= S_TX_REQ;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        S_TX_REQ: begin
          if (tx_ready) begin
            tx_send_q <= 1'b1;
            tx_byte_q <= get_lane(shift_q, k_q);
            state_q   <= S_TX_ACK;
          end
        end
        S_TX_ACK: if (!tx_ready) state_q <= S_TX_FIN;
        S_TX_FIN: begin
          if (tx_ready) begin
            if (k_q == K_LAST) begin
              state_q <= S_TX_ADV;
            end else begin
              k_q     <= k_q + KW'(1);
              state_q <= S_TX_REQ;
            end
          end
        end
        S_TX_ADV: begin
          cnt_q  <= cnt_q - (ADDR_W+1)'(1);
          addr_q <= addr_q + ADDR_W'(1);
          k_q    <= '0;
          if (cnt_q == (ADDR_W+1)'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_TX_RD;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_send   = tx_send_q;
  assign tx_byte   = tx_byte_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: a byte-wide 4-bit-address instance (A) and a
// 32-bit-word 16-bit-address instance with RD_LAT=3 (B), each with a RAM model.
module tb_uart_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] rx_byte;

  logic       ls_a, ds_a, rxd_a, txr_a, txs_a, we_a, busy_a, done_a, ovr_a;
  logic [3:0] base_a, len_a, addr_a, st_a;
  logic [7:0] txb_a, wd_a, rd_a;

  logic        ls_b, ds_b, rxd_b, txr_b, txs_b, we_b, busy_b, done_b, ovr_b;
  logic [15:0] base_b, len_b, addr_b;
  logic [3:0]  st_b;
  logic [7:0]  txb_b;
  logic [31:0] wd_b, rd_b;
  logic        hold_b;

  uart_mem_bridge #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) u_a (
    .clk(clk), .reset(reset), .load_start(ls_a), .dump_start(ds_a),
    .base_addr(base_a), .xfer_len(len_a), .rx_done(rxd_a), .rx_byte(rx_byte),
    .tx_ready(txr_a), .tx_send(txs_a), .tx_byte(txb_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wd_a), .mem_rdata(rd_a), .busy(busy_a),
    .done(done_a), .overrun(ovr_a), .state_dbg(st_a));

  uart_mem_bridge #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .load_start(ls_b), .dump_start(ds_b),
    .base_addr(base_b), .xfer_len(len_b), .rx_done(rxd_b), .rx_byte(rx_byte),
    .tx_ready(txr_b), .tx_send(txs_b), .tx_byte(txb_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wd_b), .mem_rdata(rd_b), .busy(busy_b),
    .done(done_b), .overrun(ovr_b), .state_dbg(st_b));

  // RAM models: synchronous write, RD_LAT-deep read pipelines
  logic [7:0]  mem_a [16];
  logic [7:0]  pa [2];
  logic [31:0] mem_b [256];
  logic [31:0] pb [3];

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wd_a;
    pa[0] <= mem_a[addr_a];
    pa[1] <= pa[0];
    if (we_b) mem_b[addr_b[7:0]] <= wd_b;
    pb[0] <= mem_b[addr_b[7:0]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rd_a = pa[1];
  assign rd_b = pb[2];

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wlog [$];
  logic [7:0] txl_a [$];
  logic [7:0] txl_b [$];
  int         done_a_n = 0;
  int         done_b_n = 0;

  always @(negedge clk) begin
    if (we_a) wlog.push_back('{sel: 0, addr: {12'd0, addr_a}, data: {24'd0, wd_a}});
    if (we_b) wlog.push_back('{sel: 1, addr: addr_b, data: wd_b});
    if (txs_a) txl_a.push_back(txb_a);
    if (txs_b) txl_b.push_back(txb_b);
    if (done_a) done_a_n <= done_a_n + 1;
    if (done_b) done_b_n <= done_b_n + 1;
  end

  // Transmitter models: drop tx_ready after a send, raise it 3 cycles later.
  initial begin
    txr_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (txs_a) begin
        txr_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      txr_a = 1'b1;
    end
  end

  initial begin
    txr_b = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (txs_b) begin
        txr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      txr_b = !hold_b;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic int dn(input int sel);
    return (sel == 1) ? done_b_n : done_a_n;
  endfunction

  function automatic logic [31:0] wl_addr(input int idx);
    if (idx < wlog.size()) return {16'd0, wlog[idx].addr};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wl_data(input int idx);
    if (idx < wlog.size()) return wlog[idx].data;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] tx_at(input int sel, input int idx);
    if (sel == 1 && idx < txl_b.size()) return {24'd0, txl_b[idx]};
    if (sel == 0 && idx < txl_a.size()) return {24'd0, txl_a[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic start(input int sel, input logic ld, input logic dm,
                       input logic [15:0] base, input logic [15:0] len);
    if (sel == 1) begin
      ls_b = ld; ds_b = dm; base_b = base; len_b = len;
    end else begin
      ls_a = ld; ds_a = dm; base_a = base[3:0]; len_a = len[3:0];
    end
    tick();
    ls_a = 1'b0; ds_a = 1'b0; ls_b = 1'b0; ds_b = 1'b0;
  endtask

  task automatic feed(input int sel, input logic [7:0] b);
    rx_byte = b;
    if (sel == 1) rxd_b = 1'b1; else rxd_a = 1'b1;
    tick();
    rxd_a = 1'b0; rxd_b = 1'b0;
    ticks(3);
  endtask

  task automatic wait_done(input int sel, input int d0, input string nm);
    for (int i = 0; i < 3000 && dn(sel) == d0; i++) tick();
    ticks(2);
    chk({nm, "_done_cnt"}, dn(sel) - d0, 1);
  endtask

  typedef struct {
    int          sel;
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  b0;
    logic [7:0]  step;
    int          nwr;
    logic [15:0] fa;
    logic [31:0] fd;
    logic [15:0] la;
    logic [31:0] ld;
  } lvec_t;

  lvec_t lv [4];

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, t0, bpw;
    logic [15:0] mask;
    logic [31:0] ed;
    logic [7:0]  bv;

    lv[0] = '{sel: 0, base: 16'h0000, len: 16'd4, b0: 8'h11, step: 8'h11, nwr: 4,
              fa: 16'h0000, fd: 32'h11, la: 16'h0003, ld: 32'h44};
    lv[1] = '{sel: 1, base: 16'h0010, len: 16'd2, b0: 8'h01, step: 8'h01, nwr: 2,
              fa: 16'h0010, fd: 32'h0403_0201, la: 16'h0011, ld: 32'h0807_0605};
    lv[2] = '{sel: 0, base: 16'h000E, len: 16'd4, b0: 8'hA0, step: 8'h01, nwr: 4,
              fa: 16'h000E, fd: 32'hA0, la: 16'h0001, ld: 32'hA3};
    lv[3] = '{sel: 0, base: 16'h0003, len: 16'd0, b0: 8'h00, step: 8'h01, nwr: 16,
              fa: 16'h0003, fd: 32'h00, la: 16'h0002, ld: 32'h0F};

    reset = 1'b1; rx_byte = 8'h00; hold_b = 1'b0;
    ls_a = 1'b0; ds_a = 1'b0; rxd_a = 1'b0; base_a = '0; len_a = '0;
    ls_b = 1'b0; ds_b = 1'b0; rxd_b = 1'b0; base_b = '0; len_b = '0;
    ticks(3);
    chk("rst_busy",    {busy_a, busy_b}, 0);
    chk("rst_done",    {done_a, done_b}, 0);
    chk("rst_overrun", {ovr_a, ovr_b}, 0);
    chk("rst_tx_send", {txs_a, txs_b}, 0);
    chk("rst_mem_we",  {we_a, we_b}, 0);
    chk("rst_addr",    {addr_a, addr_b}, 0);
    chk("rst_wdata_a", wd_a, 0);
    chk("rst_wdata_b", wd_b, 0);
    chk("rst_tx_byte", {txb_a, txb_b}, 0);
    reset = 1'b0;
    ticks(2);

    for (int r = 0; r < 4; r++) begin
      bpw  = (lv[r].sel == 1) ? 4 : 1;
      mask = (lv[r].sel == 1) ? 16'hFFFF : 16'h000F;
      w0 = wlog.size();
      d0 = dn(lv[r].sel);
      start(lv[r].sel, 1'b1, 1'b0, lv[r].base, lv[r].len);
      for (int j = 0; j < lv[r].nwr * bpw; j++)
        feed(lv[r].sel, lv[r].b0 + 8'(int'(lv[r].step) * j));
      wait_done(lv[r].sel, d0, $sformatf("load%0d", r));
      chk($sformatf("load%0d_nwr", r), wlog.size() - w0, lv[r].nwr);
      chk($sformatf("load%0d_first_addr", r), wl_addr(w0), {16'd0, lv[r].fa});
      chk($sformatf("load%0d_first_data", r), wl_data(w0), lv[r].fd);
      chk($sformatf("load%0d_last_addr", r), wl_addr(w0 + lv[r].nwr - 1), {16'd0, lv[r].la});
      chk($sformatf("load%0d_last_data", r), wl_data(w0 + lv[r].nwr - 1), lv[r].ld);
      for (int i = 0; i < lv[r].nwr; i++) begin
        ed = '0;
        for (int j = 0; j < bpw; j++) begin
          bv = lv[r].b0 + 8'(int'(lv[r].step) * (i * bpw + j));
          ed[8*j +: 8] = bv;
        end
        chk($sformatf("load%0d_w%0d_addr", r, i), wl_addr(w0 + i),
            {16'd0, (lv[r].base + 16'(i)) & mask});
        chk($sformatf("load%0d_w%0d_data", r, i), wl_data(w0 + i), ed);
      end
      chk($sformatf("load%0d_overrun", r), (lv[r].sel == 1) ? ovr_b : ovr_a, 0);
    end

    // Byte-wide dump across the top of the address space
    t0 = txl_a.size(); w0 = wlog.size(); d0 = done_a_n;
    start(0, 1'b0, 1'b1, 16'h000F, 16'd2);
    wait_done(0, d0, "dump_a");
    chk("dump_a_nbytes", txl_a.size() - t0, 2);
    chk("dump_a_byte0", tx_at(0, t0), 32'h0C);
    chk("dump_a_byte1", tx_at(0, t0 + 1), 32'h0D);
    chk("dump_a_no_write", wlog.size() - w0, 0);

    // Word dump of the range loaded earlier, with a stray rx_done injected
    t0 = txl_b.size(); w0 = wlog.size(); d0 = done_b_n;
    start(1, 1'b0, 1'b1, 16'h0010, 16'd2);
    rx_byte = 8'h99; rxd_b = 1'b1;
    tick();
    rxd_b = 1'b0;
    wait_done(1, d0, "dump_b");
    chk("dump_b_nbytes", txl_b.size() - t0, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("dump_b_byte%0d", i), tx_at(1, t0 + i), 32'(i + 1));
    chk("dump_b_no_write", wlog.size() - w0, 0);
    chk("dump_b_rx_no_overrun", ovr_b, 0);

    // Simultaneous starts, ignored start while busy, overrun, write latency
    w0 = wlog.size(); d0 = done_a_n; t0 = txl_a.size();
    ls_a = 1'b1; ds_a = 1'b1; base_a = 4'h5; len_a = 4'h1;
    tick();
    ls_a = 1'b0; ds_a = 1'b0;
    chk("both_start_busy", busy_a, 1);
    ds_a = 1'b1;
    tick();
    ds_a = 1'b0;
    rx_byte = 8'h5A; rxd_a = 1'b1;
    tick();
    chk("lat_we_rise", we_a, 1);
    chk("lat_we_addr", addr_a, 4'h5);
    chk("lat_we_data", wd_a, 8'h5A);
    rx_byte = 8'hEE;
    tick();
    rxd_a = 1'b0;
    chk("ovr_set", ovr_a, 1);
    chk("lat_we_one_cycle", we_a, 0);
    chk("lat_done_early", done_a, 0);
    tick();
    chk("lat_done_pulse", done_a, 1);
    ticks(10);
    chk("ovr_sticky", ovr_a, 1);
    chk("ovr_one_write", wlog.size() - w0, 1);
    chk("ovr_byte_dropped", wl_data(w0), 32'h5A);
    chk("busy_start_ignored", txl_a.size() - t0, 0);
    chk("ovr_done_cnt", done_a_n - d0, 1);
    chk("ovr_idle", busy_a, 0);

    w0 = wlog.size(); d0 = done_a_n;
    start(0, 1'b1, 1'b0, 16'h0009, 16'd1);
    chk("ovr_cleared", ovr_a, 0);
    feed(0, 8'h77);
    wait_done(0, d0, "reload");
    chk("reload_addr", wl_addr(w0), 32'h9);
    chk("reload_data", wl_data(w0), 32'h77);

    // Reset in the middle of a dump, then a fresh dump from the base
    t0 = txl_b.size(); d0 = done_b_n;
    start(1, 1'b0, 1'b1, 16'h0010, 16'd2);
    for (int i = 0; i < 2000 && txl_b.size() < t0 + 2; i++) tick();
    chk("rst_mid_two_sent", txl_b.size() - t0, 2);
    reset = 1'b1;
    tick();
    chk("rst_mid_busy", busy_b, 0);
    chk("rst_mid_tx_send", txs_b, 0);
    reset = 1'b0;
    ticks(30);
    chk("rst_mid_no_done", done_b_n - d0, 0);
    chk("rst_mid_no_more_tx", txl_b.size() - t0, 2);
    t0 = txl_b.size(); d0 = done_b_n;
    start(1, 1'b0, 1'b1, 16'h0010, 16'd2);
    wait_done(1, d0, "redump");
    chk("redump_nbytes", txl_b.size() - t0, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("redump_byte%0d", i), tx_at(1, t0 + i), 32'(i + 1));

    // Transmitter held busy for 50 cycles with RD_LAT=3
    hold_b = 1'b1;
    ticks(4);
    t0 = txl_b.size(); d0 = done_b_n;
    start(1, 1'b0, 1'b1, 16'h0011, 16'd1);
    ticks(50);
    chk("hold_no_send", txl_b.size() - t0, 0);
    chk("hold_busy", busy_b, 1);
    hold_b = 1'b0;
    wait_done(1, d0, "hold");
    chk("hold_nbytes", txl_b.size() - t0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("hold_byte%0d", i), tx_at(1, t0 + i), 32'(i + 5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
